// File: rtl/lc3b_write_buffer.sv
// Write-back buffer between the L1 data cache and memory: queues evicted dirty lines,
// coalesces rewrites of a queued line, drains one line at a time and serves lookups.
module lc3b_write_buffer #(
    parameter int DEPTH   = 4,
    parameter int LINE_W  = 128,
    parameter int LADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [LADDR_W-1:0]         enq_addr,
    input  logic [LINE_W-1:0]          enq_data,
    input  logic [LADDR_W-1:0]         lk_addr,
    output logic                       lk_hit,
    output logic [LINE_W-1:0]          lk_data,
    output logic                       mem_write,
    output logic [LADDR_W-1:0]         mem_address,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic                       mem_resp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DEPTH-1:0]   r_valid;
    logic [LADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0]  r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_locked;
    logic               w_enq;
    logic               w_pop;
    logic               w_push;
    logic [PTR_W-1:0]   w_idx;
    logic               w_co_hit;
    logic [PTR_W-1:0]   w_co_idx;
    logic               w_lk_hit;
    logic [PTR_W-1:0]   w_lk_idx;
    logic [PTR_W-1:0]   w_wr_idx;

    assign w_locked  = (r_state == S_WRITE);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign enq_ready = !full;
    assign count     = r_count;
    assign w_enq     = enq_valid && enq_ready;
    assign w_pop     = w_locked && mem_resp;
    assign w_push    = w_enq && !w_co_hit;
    assign w_wr_idx  = w_co_hit ? w_co_idx : r_tail;

    // Scan oldest-to-youngest so the last match found is the one nearest the tail.
    always_comb begin
        w_idx    = r_head;
        w_co_hit = 1'b0;
        w_co_idx = r_tail;
        w_lk_hit = 1'b0;
        w_lk_idx = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == enq_addr) &&
                !(w_locked && (w_idx == r_head))) begin
                w_co_hit = 1'b1;
                w_co_idx = w_idx;
            end
            if (r_valid[w_idx] && (r_addr[w_idx] == lk_addr)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = w_idx;
            end
        end
    end

    assign lk_hit      = w_lk_hit;
    assign lk_data     = w_lk_hit ? r_data[w_lk_idx] : '0;
    assign mem_address = r_valid[r_head] ? r_addr[r_head] : '0;
    assign mem_wdata   = r_valid[r_head] ? r_data[r_head] : '0;

    always_comb begin
        w_state_nxt = r_state;
        mem_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!empty) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                if (mem_resp) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            // The head is locked during WRITE, so pop and push never touch the same slot.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[w_wr_idx] <= enq_addr;
            r_data[w_wr_idx] <= enq_data;
        end
    end
endmodule

// File: tb/tb_lc3b_write_buffer.sv
// Bench for lc3b_write_buffer: vector table for fill/lookup, hand sequences for drain corners,
// and a scoreboard of expected memory writes.
module tb_lc3b_write_buffer;
    localparam int DEPTH   = 4;
    localparam int LINE_W  = 128;
    localparam int LADDR_W = 12;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic               clk;
    logic               rst;
    logic               enq_valid;
    logic               enq_ready;
    logic [LADDR_W-1:0] enq_addr;
    logic [LINE_W-1:0]  enq_data;
    logic [LADDR_W-1:0] lk_addr;
    logic               lk_hit;
    logic [LINE_W-1:0]  lk_data;
    logic               mem_write;
    logic [LADDR_W-1:0] mem_address;
    logic [LINE_W-1:0]  mem_wdata;
    logic               mem_resp;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;

    lc3b_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .LADDR_W(LADDR_W)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LADDR_W-1:0] addr;
        logic [LINE_W-1:0]  data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic               en;
        logic [LADDR_W-1:0] addr;
        logic [LINE_W-1:0]  data;
        logic [LADDR_W-1:0] lk;
        logic               resp;
        logic [CNT_W-1:0]   cnt;
        logic               full;
        logic               hit;
        logic [LINE_W-1:0]  lkd;
        logic               mw;
        logic [LADDR_W-1:0] maddr;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [LINE_W-1:0] mk(input logic [7:0] n);
        return {16{n}};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mkwr(input logic [LADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    // Completed writes (mem_write && mem_resp at an edge) are checked against the queue.
    always @(posedge clk) begin
        if (!rst && mem_write && mem_resp) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_address, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_address !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL mem_write_sb: got %0h/%0h expected %0h/%0h",
                             mem_address, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic respond_one(input string name);
        int n;
        n = 0;
        while (!mem_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_write) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got mem_write=0 expected 1 within 50 cycles", name);
        end else begin
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic any_write;
        vecs[0] = '{1'b1, 12'h012, mk(8'hA1), 12'h012, 1'b0, 3'd1, 1'b0, 1'b1, mk(8'hA1), 1'b0, 12'h012};
        vecs[1] = '{1'b0, 12'h000, '0,        12'h012, 1'b0, 3'd1, 1'b0, 1'b1, mk(8'hA1), 1'b1, 12'h012};
        vecs[2] = '{1'b0, 12'h000, '0,        12'h012, 1'b1, 3'd0, 1'b0, 1'b0, '0,        1'b0, 12'h000};
        vecs[3] = '{1'b1, 12'h001, mk(8'h01), 12'h001, 1'b0, 3'd1, 1'b0, 1'b1, mk(8'h01), 1'b0, 12'h001};
        vecs[4] = '{1'b1, 12'h002, mk(8'h02), 12'h001, 1'b0, 3'd2, 1'b0, 1'b1, mk(8'h01), 1'b1, 12'h001};
        vecs[5] = '{1'b1, 12'h003, mk(8'h03), 12'h003, 1'b0, 3'd3, 1'b0, 1'b1, mk(8'h03), 1'b1, 12'h001};
        vecs[6] = '{1'b1, 12'h004, mk(8'h04), 12'h004, 1'b0, 3'd4, 1'b1, 1'b1, mk(8'h04), 1'b1, 12'h001};
        vecs[7] = '{1'b1, 12'h009, mk(8'h09), 12'h009, 1'b0, 3'd4, 1'b1, 1'b0, '0,        1'b1, 12'h001};

        rst = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; lk_addr = 12'h012; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", LINE_W'(count), '0);
        chk("rst_empty", LINE_W'(empty), 1);
        chk("rst_full", LINE_W'(full), 0);
        chk("rst_enq_ready", LINE_W'(enq_ready), 1);
        chk("rst_mem_write", LINE_W'(mem_write), 0);
        chk("rst_lk_hit", LINE_W'(lk_hit), 0);
        chk("rst_lk_data", lk_data, '0);
        chk("rst_mem_address", LINE_W'(mem_address), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        rst = 1'b0;

        exp_q.push_back(mkwr(12'h012, mk(8'hA1)));
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int a = 1; a <= 4; a++) exp_q.push_back(mkwr(LADDR_W'(a), mk(8'(a))));
            end
            enq_valid = vecs[i].en; enq_addr = vecs[i].addr; enq_data = vecs[i].data;
            lk_addr = vecs[i].lk; mem_resp = vecs[i].resp;
            @(negedge clk);
            chk($sformatf("v%0d_count", i), LINE_W'(count), LINE_W'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i), LINE_W'(full), LINE_W'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), LINE_W'(empty), LINE_W'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_enq_ready", i), LINE_W'(enq_ready), LINE_W'(!vecs[i].full));
            chk($sformatf("v%0d_lk_hit", i), LINE_W'(lk_hit), LINE_W'(vecs[i].hit));
            chk($sformatf("v%0d_lk_data", i), lk_data, vecs[i].lkd);
            chk($sformatf("v%0d_mem_write", i), LINE_W'(mem_write), LINE_W'(vecs[i].mw));
            chk($sformatf("v%0d_mem_address", i), LINE_W'(mem_address), LINE_W'(vecs[i].maddr));
        end

        // Full buffer: pop and refused enqueue in the same cycle.
        enq_valid = 1'b1; enq_addr = 12'h00A; enq_data = mk(8'h0A); lk_addr = 12'h00A; mem_resp = 1'b1;
        @(negedge clk);
        enq_valid = 1'b0; mem_resp = 1'b0;
        chk("fullpop_count", LINE_W'(count), 3);
        chk("fullpop_enq_ready", LINE_W'(enq_ready), 1);
        chk("fullpop_lk_hit", LINE_W'(lk_hit), 0);
        chk("fullpop_mem_write", LINE_W'(mem_write), 0);
        respond_one("drain2");
        respond_one("drain3");
        respond_one("drain4");
        chk("drained_empty", LINE_W'(empty), 1);

        // Coalesce into an unlocked entry.
        exp_q.push_back(mkwr(12'h005, mk(8'hC5)));
        enq_valid = 1'b1; enq_addr = 12'h005; enq_data = mk(8'hB5); lk_addr = 12'h005;
        @(negedge clk);
        enq_data = mk(8'hC5);
        @(negedge clk);
        enq_valid = 1'b0;
        chk("coal_count", LINE_W'(count), 1);
        chk("coal_lk_data", lk_data, mk(8'hC5));
        chk("coal_mem_write", LINE_W'(mem_write), 1);
        chk("coal_mem_wdata", mem_wdata, mk(8'hC5));
        respond_one("coal");
        any_write = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_write = any_write | mem_write;
        end
        chk("coal_single_write", LINE_W'(any_write), 0);

        // Same address as the locked head appends a new entry.
        exp_q.push_back(mkwr(12'h007, mk(8'hD7)));
        exp_q.push_back(mkwr(12'h007, mk(8'hE7)));
        enq_valid = 1'b1; enq_addr = 12'h007; enq_data = mk(8'hD7); lk_addr = 12'h007;
        @(negedge clk);
        enq_valid = 1'b0;
        @(negedge clk);
        chk("lock_latency_mem_write", LINE_W'(mem_write), 1);
        enq_valid = 1'b1; enq_data = mk(8'hE7);
        @(negedge clk);
        enq_valid = 1'b0;
        chk("lock_count", LINE_W'(count), 2);
        chk("lock_lk_data", lk_data, mk(8'hE7));
        chk("lock_mem_wdata", mem_wdata, mk(8'hD7));
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("lock_gap_mem_write", LINE_W'(mem_write), 0);
        chk("lock_gap_count", LINE_W'(count), 1);
        @(negedge clk);
        chk("lock_second_mem_write", LINE_W'(mem_write), 1);
        chk("lock_second_wdata", mem_wdata, mk(8'hE7));
        respond_one("lock_second");

        // Asynchronous reset in the middle of a WRITE.
        for (int a = 0; a < 3; a++) begin
            enq_valid = 1'b1; enq_addr = 12'h021 + LADDR_W'(a); enq_data = mk(8'h21 + 8'(a));
            @(negedge clk);
        end
        enq_valid = 1'b0; lk_addr = 12'h021;
        chk("prerst_mem_write", LINE_W'(mem_write), 1);
        chk("prerst_count", LINE_W'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_write", LINE_W'(mem_write), 0);
        chk("arst_count", LINE_W'(count), 0);
        chk("arst_empty", LINE_W'(empty), 1);
        chk("arst_lk_hit", LINE_W'(lk_hit), 0);
        chk("arst_lk_data", lk_data, '0);
        @(negedge clk);
        rst = 1'b0;
        any_write = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_write = any_write | mem_write;
        end
        chk("postrst_no_write", LINE_W'(any_write), 0);
        chk("sb_leftover", LINE_W'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
